// File: rtl/pipe_hazard_ctrl_if.sv
`default_nettype none
//==============================================================================
// Module   : pipe_hazard_ctrl_if
// Purpose  : ID-stage request, pipeline control and forwarding-tag bundle.
// Revision : 1.0 - initial release
//==============================================================================
interface pipe_hazard_ctrl_if #(
  parameter int CNT_W = 16
);
  logic             id_valid;
  logic [4:0]       id_rs;
  logic [4:0]       id_rt;
  logic             id_uses_rs;
  logic             id_uses_rt;
  logic [4:0]       id_rd;
  logic             id_regwr;
  logic             id_memread;
  logic             br_taken;
  logic             ext_stall;

  logic             pc_we;
  logic             ifid_we;
  logic             ifid_flush;
  logic             idex_bubble;
  logic [4:0]       ex_rd;
  logic             ex_regwr;
  logic             ex_memread;
  logic [4:0]       exmem_rd;
  logic             exmem_regwr;
  logic [4:0]       memwr_rd;
  logic             memwr_regwr;
  logic [CNT_W-1:0] bubble_cnt;
  logic [CNT_W-1:0] flush_cnt;

  modport master (
    output id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwr, id_memread, br_taken, ext_stall,
    input  pc_we, ifid_we, ifid_flush, idex_bubble,
           ex_rd, ex_regwr, ex_memread, exmem_rd, exmem_regwr,
           memwr_rd, memwr_regwr, bubble_cnt, flush_cnt
  );

  modport slave (
    input  id_valid, id_rs, id_rt, id_uses_rs, id_uses_rt, id_rd,
           id_regwr, id_memread, br_taken, ext_stall,
    output pc_we, ifid_we, ifid_flush, idex_bubble,
           ex_rd, ex_regwr, ex_memread, exmem_rd, exmem_regwr,
           memwr_rd, memwr_regwr, bubble_cnt, flush_cnt
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : pipe_hazard_ctrl
// Purpose  : Load-use / branch / memory-stall control with EX-MEM-WB tag pipe.
// Revision : 1.0 - initial release
//==============================================================================
module pipe_hazard_ctrl #(
  parameter int CNT_W   = 16,
  parameter bit MEM_FWD = 1'b1
) (
  input  wire logic         clk,
  input  wire logic         resetn,
  pipe_hazard_ctrl_if.slave bus
);

  localparam logic [4:0]       c_regZero = 5'd0;
  localparam logic [CNT_W-1:0] c_cntMax  = {CNT_W{1'b1}};

  logic [4:0]       r_exRd;
  logic             r_exRegwr;
  logic             r_exMemread;
  logic [4:0]       r_exmemRd;
  logic             r_exmemRegwr;
  logic [4:0]       r_memwrRd;
  logic             r_memwrRegwr;
  logic [CNT_W-1:0] r_bubbleCnt;
  logic [CNT_W-1:0] r_flushCnt;

  logic w_idRegwr;
  logic w_idMemread;
  logic w_luEx;
  logic w_luMem;
  logic w_lu;
  logic w_advance;
  logic w_pcWe;
  logic w_ifidWe;
  logic w_ifidFlush;
  logic w_idexBubble;
  logic w_countBubble;
  logic w_countFlush;

  function automatic logic tagHit(
    input logic [4:0] sRd,
    input logic       sRegwr,
    input logic       idValid,
    input logic       usesRs,
    input logic [4:0] rs,
    input logic       usesRt,
    input logic [4:0] rt
  );
    return sRegwr && (sRd != c_regZero) && idValid &&
           ((usesRs && (rs == sRd)) || (usesRt && (rt == sRd)));
  endfunction

  // Register 0 is never a real destination, so it never carries a write tag.
  assign w_idRegwr   = bus.id_regwr && bus.id_valid && (bus.id_rd != c_regZero);
  assign w_idMemread = bus.id_memread && bus.id_valid;
  assign w_advance   = !bus.ext_stall;

  assign w_luEx = r_exMemread &&
                  tagHit(r_exRd, r_exRegwr, bus.id_valid,
                         bus.id_uses_rs, bus.id_rs, bus.id_uses_rt, bus.id_rt);

  generate
    if (MEM_FWD) begin : g_memFwd
      assign w_luMem = 1'b0;
    end else begin : g_rfOnly
      // Without a MEM/WB bypass, a load still in EX/MEM must also hold the consumer.
      logic r_exmemMemread;

      always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
          r_exmemMemread <= 1'b0;
        end else if (w_advance) begin
          r_exmemMemread <= r_exMemread;
        end
      end

      assign w_luMem = r_exmemMemread &&
                       tagHit(r_exmemRd, r_exmemRegwr, bus.id_valid,
                              bus.id_uses_rs, bus.id_rs, bus.id_uses_rt, bus.id_rt);
    end
  endgenerate

  assign w_lu = w_luEx || w_luMem;

  always_comb begin
    w_pcWe        = 1'b1;
    w_ifidWe      = 1'b1;
    w_ifidFlush   = 1'b0;
    w_idexBubble  = 1'b0;
    w_countBubble = 1'b0;
    w_countFlush  = 1'b0;
    if (bus.ext_stall) begin
      w_pcWe   = 1'b0;
      w_ifidWe = 1'b0;
    end else if (bus.br_taken) begin
      w_ifidFlush  = 1'b1;
      w_idexBubble = 1'b1;
      w_countFlush = 1'b1;
    end else if (w_lu) begin
      w_pcWe        = 1'b0;
      w_ifidWe      = 1'b0;
      w_idexBubble  = 1'b1;
      w_countBubble = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_exRd       <= c_regZero;
      r_exRegwr    <= 1'b0;
      r_exMemread  <= 1'b0;
      r_exmemRd    <= c_regZero;
      r_exmemRegwr <= 1'b0;
      r_memwrRd    <= c_regZero;
      r_memwrRegwr <= 1'b0;
    end else if (w_advance) begin
      r_memwrRd    <= r_exmemRd;
      r_memwrRegwr <= r_exmemRegwr;
      r_exmemRd    <= r_exRd;
      r_exmemRegwr <= r_exRegwr;
      if (w_idexBubble) begin
        r_exRd      <= c_regZero;
        r_exRegwr   <= 1'b0;
        r_exMemread <= 1'b0;
      end else begin
        r_exRd      <= bus.id_rd;
        r_exRegwr   <= w_idRegwr;
        r_exMemread <= w_idMemread;
      end
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_bubbleCnt <= '0;
      r_flushCnt  <= '0;
    end else begin
      if (w_countBubble && (r_bubbleCnt != c_cntMax)) begin
        r_bubbleCnt <= r_bubbleCnt + 1'b1;
      end
      if (w_countFlush && (r_flushCnt != c_cntMax)) begin
        r_flushCnt <= r_flushCnt + 1'b1;
      end
    end
  end

  assign bus.pc_we       = w_pcWe;
  assign bus.ifid_we     = w_ifidWe;
  assign bus.ifid_flush  = w_ifidFlush;
  assign bus.idex_bubble = w_idexBubble;
  assign bus.ex_rd       = r_exRd;
  assign bus.ex_regwr    = r_exRegwr;
  assign bus.ex_memread  = r_exMemread;
  assign bus.exmem_rd    = r_exmemRd;
  assign bus.exmem_regwr = r_exmemRegwr;
  assign bus.memwr_rd    = r_memwrRd;
  assign bus.memwr_regwr = r_memwrRegwr;
  assign bus.bubble_cnt  = r_bubbleCnt;
  assign bus.flush_cnt   = r_flushCnt;

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
//==============================================================================
// Module   : tb_pipe_hazard_ctrl
// Purpose  : Directed scoreboard bench; dutA has MEM/WB bypass, dutB does not.
// Revision : 1.0 - initial release
//==============================================================================
module tb_pipe_hazard_ctrl;

  localparam int c_dutA     = 0;
  localparam int c_dutB     = 1;
  localparam int c_sPcWe    = 0;
  localparam int c_sIfidWe  = 1;
  localparam int c_sFlush   = 2;
  localparam int c_sBubble  = 3;
  localparam int c_sExRd    = 4;
  localparam int c_sExRw    = 5;
  localparam int c_sExMr    = 6;
  localparam int c_sEmRd    = 7;
  localparam int c_sEmRw    = 8;
  localparam int c_sMwRd    = 9;
  localparam int c_sMwRw    = 10;
  localparam int c_sBcnt    = 11;
  localparam int c_sFcnt    = 12;
  localparam int c_satB     = 15;

  typedef struct {
    int cyc;
    int dut;
    int sig;
    int expv;
  } expEntry_t;

  logic clk    = 1'b1;
  logic resetn = 1'b1;
  always #5 clk = ~clk;

  logic       r_idValid;
  logic [4:0] r_idRs;
  logic [4:0] r_idRt;
  logic       r_idUsesRs;
  logic       r_idUsesRt;
  logic [4:0] r_idRd;
  logic       r_idRegwr;
  logic       r_idMemread;
  logic       r_brTaken;
  logic       r_extStall;

  pipe_hazard_ctrl_if #(.CNT_W(16)) ifA ();
  pipe_hazard_ctrl_if #(.CNT_W(4))  ifB ();

  assign ifA.id_valid   = r_idValid;    assign ifB.id_valid   = r_idValid;
  assign ifA.id_rs      = r_idRs;       assign ifB.id_rs      = r_idRs;
  assign ifA.id_rt      = r_idRt;       assign ifB.id_rt      = r_idRt;
  assign ifA.id_uses_rs = r_idUsesRs;   assign ifB.id_uses_rs = r_idUsesRs;
  assign ifA.id_uses_rt = r_idUsesRt;   assign ifB.id_uses_rt = r_idUsesRt;
  assign ifA.id_rd      = r_idRd;       assign ifB.id_rd      = r_idRd;
  assign ifA.id_regwr   = r_idRegwr;    assign ifB.id_regwr   = r_idRegwr;
  assign ifA.id_memread = r_idMemread;  assign ifB.id_memread = r_idMemread;
  assign ifA.br_taken   = r_brTaken;    assign ifB.br_taken   = r_brTaken;
  assign ifA.ext_stall  = r_extStall;   assign ifB.ext_stall  = r_extStall;

  pipe_hazard_ctrl #(.CNT_W(16), .MEM_FWD(1'b1)) dutA (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifA.slave)
  );

  pipe_hazard_ctrl #(.CNT_W(4), .MEM_FWD(1'b0)) dutB (
    .clk    (clk),
    .resetn (resetn),
    .bus    (ifB.slave)
  );

  expEntry_t q[$];
  int cyc    = 0;
  int checks = 0;
  int errors = 0;

  function automatic int actual(input int dut, input int sig);
    if (dut == c_dutA) begin
      case (sig)
        c_sPcWe:   return int'(ifA.pc_we);
        c_sIfidWe: return int'(ifA.ifid_we);
        c_sFlush:  return int'(ifA.ifid_flush);
        c_sBubble: return int'(ifA.idex_bubble);
        c_sExRd:   return int'(ifA.ex_rd);
        c_sExRw:   return int'(ifA.ex_regwr);
        c_sExMr:   return int'(ifA.ex_memread);
        c_sEmRd:   return int'(ifA.exmem_rd);
        c_sEmRw:   return int'(ifA.exmem_regwr);
        c_sMwRd:   return int'(ifA.memwr_rd);
        c_sMwRw:   return int'(ifA.memwr_regwr);
        c_sBcnt:   return int'(ifA.bubble_cnt);
        default:   return int'(ifA.flush_cnt);
      endcase
    end
    case (sig)
      c_sPcWe:   return int'(ifB.pc_we);
      c_sIfidWe: return int'(ifB.ifid_we);
      c_sFlush:  return int'(ifB.ifid_flush);
      c_sBubble: return int'(ifB.idex_bubble);
      c_sExRd:   return int'(ifB.ex_rd);
      c_sExRw:   return int'(ifB.ex_regwr);
      c_sExMr:   return int'(ifB.ex_memread);
      c_sEmRd:   return int'(ifB.exmem_rd);
      c_sEmRw:   return int'(ifB.exmem_regwr);
      c_sMwRd:   return int'(ifB.memwr_rd);
      c_sMwRw:   return int'(ifB.memwr_regwr);
      c_sBcnt:   return int'(ifB.bubble_cnt);
      default:   return int'(ifB.flush_cnt);
    endcase
  endfunction

  function automatic string sigName(input int sig);
    case (sig)
      c_sPcWe:   return "pc_we";
      c_sIfidWe: return "ifid_we";
      c_sFlush:  return "ifid_flush";
      c_sBubble: return "idex_bubble";
      c_sExRd:   return "ex_rd";
      c_sExRw:   return "ex_regwr";
      c_sExMr:   return "ex_memread";
      c_sEmRd:   return "exmem_rd";
      c_sEmRw:   return "exmem_regwr";
      c_sMwRd:   return "memwr_rd";
      c_sMwRw:   return "memwr_regwr";
      c_sBcnt:   return "bubble_cnt";
      default:   return "flush_cnt";
    endcase
  endfunction

  // Monitor: every expectation is stamped with the cycle it belongs to.
  initial begin
    expEntry_t e;
    int a;
    forever begin
      @(negedge clk);
      while ((q.size() > 0) && (q[0].cyc == cyc)) begin
        e = q.pop_front();
        a = actual(e.dut, e.sig);
        checks++;
        if (a != e.expv) begin
          errors++;
          $display("FAIL %s dut%s cycle %0d: got %0d, expected %0d",
                   sigName(e.sig), (e.dut == c_dutA) ? "A" : "B", e.cyc, a, e.expv);
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic want(input int dut, input int sig, input int val);
    q.push_back('{cyc, dut, sig, val});
  endtask

  task automatic wantBoth(input int sig, input int val);
    want(c_dutA, sig, val);
    want(c_dutB, sig, val);
  endtask

  task automatic wantCtl(input int dut, input int pc, input int ifid, input int fl, input int bub);
    want(dut, c_sPcWe, pc);
    want(dut, c_sIfidWe, ifid);
    want(dut, c_sFlush, fl);
    want(dut, c_sBubble, bub);
  endtask

  task automatic setId(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] rd,
                       input logic rw, input logic mr);
    r_idValid   = v;
    r_idRs      = rs;
    r_idRt      = rt;
    r_idUsesRs  = urs;
    r_idUsesRt  = urt;
    r_idRd      = rd;
    r_idRegwr   = rw;
    r_idMemread = mr;
  endtask

  task automatic nopId(); setId(1'b0, 5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0); endtask
  task automatic lw8();   setId(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd8, 1'b1, 1'b1); endtask
  task automatic add9();  setId(1'b1, 5'd8, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0); endtask
  task automatic alu(input logic [4:0] rd); setId(1'b1, 5'd1, 5'd2, 1'b1, 1'b1, rd, 1'b1, 1'b0); endtask

  initial begin
    #100000;
    errors++;
    $display("FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    int expB;
    r_brTaken  = 1'b0;
    r_extStall = 1'b0;
    nopId();
    resetn = 1'b0;
    tick();
    for (int d = 0; d < 2; d++) begin
      wantCtl(d, 1, 1, 0, 0);
      for (int s = c_sExRd; s <= c_sFcnt; s++) want(d, s, 0);
    end
    tick();
    resetn = 1'b1;

    // Independent ALU stream
    alu(5'd3); wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0); tick();
    alu(5'd4); wantBoth(c_sExRd, 3); wantBoth(c_sExRw, 1); wantBoth(c_sPcWe, 1); tick();
    alu(5'd5); wantBoth(c_sExRd, 4); wantBoth(c_sEmRd, 3); wantBoth(c_sEmRw, 1); tick();
    nopId();   wantBoth(c_sMwRd, 3); wantBoth(c_sMwRw, 1); wantBoth(c_sEmRd, 4);
               wantBoth(c_sExRd, 5); wantBoth(c_sBcnt, 0); wantBoth(c_sPcWe, 1); tick();

    // Load-use, single stall with MEM/WB bypass
    lw8();  wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0); tick();
    add9(); wantCtl(c_dutA, 0, 0, 0, 1); wantCtl(c_dutB, 0, 0, 0, 1);
            want(c_dutA, c_sExRd, 8); want(c_dutA, c_sExMr, 1); want(c_dutA, c_sBcnt, 0); tick();
    add9(); wantCtl(c_dutA, 1, 1, 0, 0); want(c_dutA, c_sBcnt, 1); want(c_dutA, c_sExRd, 0);
            want(c_dutA, c_sExRw, 0); want(c_dutA, c_sEmRd, 8);
            wantCtl(c_dutB, 0, 0, 0, 1); want(c_dutB, c_sBcnt, 1); tick();
    nopId(); want(c_dutA, c_sExRd, 9); want(c_dutA, c_sExRw, 1); want(c_dutA, c_sExMr, 0);
             want(c_dutA, c_sBcnt, 1); wantCtl(c_dutA, 1, 1, 0, 0); tick();

    // Async reset clears counters immediately; then two-stall load-use without bypass
    resetn = 1'b0; want(c_dutA, c_sBcnt, 0); want(c_dutA, c_sExRd, 0); want(c_dutB, c_sBcnt, 0); tick();
    resetn = 1'b1;
    lw8();  wantCtl(c_dutB, 1, 1, 0, 0); tick();
    add9(); wantCtl(c_dutB, 0, 0, 0, 1); want(c_dutB, c_sBcnt, 0); tick();
    add9(); wantCtl(c_dutB, 0, 0, 0, 1); want(c_dutB, c_sBcnt, 1); want(c_dutB, c_sExRd, 0);
            want(c_dutB, c_sEmRd, 8); tick();
    add9(); wantCtl(c_dutB, 1, 1, 0, 0); want(c_dutB, c_sBcnt, 2); want(c_dutB, c_sEmRd, 0);
            want(c_dutB, c_sMwRd, 8); tick();
    nopId(); want(c_dutB, c_sExRd, 9); want(c_dutB, c_sExRw, 1); want(c_dutB, c_sBcnt, 2);
             wantCtl(c_dutB, 1, 1, 0, 0); tick();

    // Register 0 never hazards
    resetn = 1'b0; tick();
    resetn = 1'b1;
    setId(1'b1, 5'd1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b1, 1'b1);
    wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0); tick();
    setId(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0);
    wantBoth(c_sExRd, 0); wantBoth(c_sExRw, 0); wantBoth(c_sExMr, 1); tick();
    setId(1'b1, 5'd0, 5'd2, 1'b1, 1'b1, 5'd9, 1'b1, 1'b0);
    wantCtl(c_dutB, 1, 1, 0, 0); want(c_dutB, c_sEmRw, 0); wantBoth(c_sBcnt, 0); tick();

    // Taken branch overrides a simultaneous load-use
    lw8();  wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0); tick();
    add9(); r_brTaken = 1'b1;
            wantCtl(c_dutA, 1, 1, 1, 1); wantCtl(c_dutB, 1, 1, 1, 1);
            wantBoth(c_sFcnt, 0); wantBoth(c_sBcnt, 0); tick();
    nopId(); r_brTaken = 1'b0;
             wantBoth(c_sFcnt, 1); wantBoth(c_sBcnt, 0); wantBoth(c_sExRd, 0);
             wantBoth(c_sExRw, 0); wantBoth(c_sEmRd, 8);
             wantCtl(c_dutA, 1, 1, 0, 0); wantCtl(c_dutB, 1, 1, 0, 0); tick();

    // External stall freezes a pending load-use
    lw8(); wantCtl(c_dutA, 1, 1, 0, 0); tick();
    r_extStall = 1'b1;
    add9();
    for (int i = 0; i < 3; i++) begin
      wantCtl(c_dutA, 0, 0, 0, 0); want(c_dutA, c_sExRd, 8); want(c_dutA, c_sExMr, 1);
      want(c_dutA, c_sEmRd, 0); want(c_dutA, c_sMwRd, 0);
      want(c_dutA, c_sBcnt, 0); want(c_dutA, c_sFcnt, 1); tick();
    end
    r_extStall = 1'b0;
    wantCtl(c_dutA, 0, 0, 0, 1); want(c_dutA, c_sBcnt, 0); tick();
    wantCtl(c_dutA, 1, 1, 0, 0); want(c_dutA, c_sBcnt, 1); want(c_dutA, c_sEmRd, 8); tick();
    nopId(); want(c_dutA, c_sExRd, 9); tick();

    // Saturation of the 4-bit bubble counter in dutB (18 bubbles, max 15)
    resetn = 1'b0; tick();
    resetn = 1'b1;
    expB = 0;
    for (int p = 0; p < 9; p++) begin
      lw8(); wantCtl(c_dutB, 1, 1, 0, 0); want(c_dutB, c_sBcnt, expB); tick();
      for (int k = 0; k < 3; k++) begin
        add9();
        if (k < 2) wantCtl(c_dutB, 0, 0, 0, 1);
        else       wantCtl(c_dutB, 1, 1, 0, 0);
        want(c_dutB, c_sBcnt, expB);
        tick();
        if ((k < 2) && (expB < c_satB)) expB++;
      end
    end

    // Reset asserted in the middle of a two-cycle stall
    lw8(); tick();
    add9(); wantCtl(c_dutB, 0, 0, 0, 1); want(c_dutB, c_sBcnt, c_satB); tick();
    add9(); resetn = 1'b0;
    wantCtl(c_dutB, 1, 1, 0, 0); want(c_dutB, c_sBcnt, 0); want(c_dutB, c_sEmRd, 0);
    want(c_dutB, c_sMwRd, 0); want(c_dutB, c_sExRd, 0); wantCtl(c_dutA, 1, 1, 0, 0); tick();
    resetn = 1'b1;
    nopId();
    tick();
    tick();

    if (q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
